// File: rtl/timecnt_pkg.sv
// rtl/timecnt_pkg.sv - channel state encoding and helpers for the elapsed timer bank
package timecnt_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } chan_state_t;

    // Largest value an unsigned counter of the given width can hold
    function automatic logic [63:0] count_max(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/timecnt_channel.sv
// rtl/timecnt_channel.sv - one timer channel: FSM, prescaler, counter, overflow (TIMECNT_WRAP_EN selects wrap vs saturate)
import timecnt_pkg::*;

module timecnt_channel #(
    parameter int COUNT_W  = 16,
    parameter int TICK_DIV = 48000000,
    parameter int PRESC_W  = 26
) (
    input  logic               MCLK,
    input  logic               nRESET,
    input  logic               nSTART,
    input  logic               nCLR,
    input  logic               PAUSE,
    output logic [COUNT_W-1:0] TIMEELAPSED,
    output logic               RUNNING,
    output logic               OVFL
);

    localparam logic [COUNT_W-1:0] CNT_MAX    = COUNT_W'(count_max(COUNT_W));
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    chan_state_t        state;
    logic [PRESC_W-1:0] presc;
    logic [COUNT_W-1:0] count;
    logic               running;
    logic               ovfl;

    assign TIMEELAPSED = count;
    assign RUNNING     = running;
    assign OVFL        = ovfl;

    // Channel FSM; clear dominates everything but reset, start is only honoured from IDLE
    always_ff @(posedge MCLK) begin
        if (!nRESET || !nCLR) begin
            state   <= ST_IDLE;
            presc   <= '0;
            count   <= '0;
            running <= 1'b0;
            ovfl    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!nSTART) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                        presc   <= '0;
                    end
                end
                ST_RUN: begin
                    if (PAUSE) begin
                        state   <= ST_HOLD;
                        running <= 1'b0;
                    end else if (presc == PRESC_LAST) begin
                        presc <= '0;
                        if (count == CNT_MAX) begin
                            ovfl <= 1'b1;
`ifdef TIMECNT_WRAP_EN
                            count <= '0;
`else
                            count <= CNT_MAX;
`endif
                        end else begin
                            count <= count + 1'b1;
                        end
                    end else begin
`ifdef TIMECNT_WRAP_EN
                        presc <= presc + 1'b1;
`else
                        // once saturated the prescaler parks at 0 until cleared
                        if (!ovfl) begin
                            presc <= presc + 1'b1;
                        end
`endif
                    end
                end
                ST_HOLD: begin
                    // partial tick is kept; counting resumes from the frozen prescaler
                    if (!PAUSE) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/elapsed_timer_bank.sv
// rtl/elapsed_timer_bank.sv - multi-channel elapsed timer with coherent snapshot (TIMECNT_WRAP_EN selects wrap vs saturate)
import timecnt_pkg::*;

module elapsed_timer_bank #(
    parameter int CHANNELS = 4,
    parameter int COUNT_W  = 16,
    parameter int TICK_DIV = 48000000,
    parameter int PRESC_W  = 26
) (
    input  logic                          MCLK,
    input  logic                          nRESET,
    input  logic [CHANNELS-1:0]           nSTART,
    input  logic [CHANNELS-1:0]           nCLR,
    input  logic [CHANNELS-1:0]           PAUSE,
    input  logic                          SNAP,
    output logic [CHANNELS*COUNT_W-1:0]   TIMEELAPSED,
    output logic [CHANNELS*COUNT_W-1:0]   SNAPSHOT,
    output logic [CHANNELS-1:0]           RUNNING,
    output logic [CHANNELS-1:0]           OVFL
);

    logic [CHANNELS*COUNT_W-1:0] snap_q;

    assign SNAPSHOT = snap_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        timecnt_channel #(
            .COUNT_W  (COUNT_W),
            .TICK_DIV (TICK_DIV),
            .PRESC_W  (PRESC_W)
        ) u_chan (
            .MCLK        (MCLK),
            .nRESET      (nRESET),
            .nSTART      (nSTART[g]),
            .nCLR        (nCLR[g]),
            .PAUSE       (PAUSE[g]),
            .TIMEELAPSED (TIMEELAPSED[g*COUNT_W +: COUNT_W]),
            .RUNNING     (RUNNING[g]),
            .OVFL        (OVFL[g])
        );
    end

    // Capture all live counts in the same cycle so the snapshot is coherent
    always_ff @(posedge MCLK) begin
        if (!nRESET) begin
            snap_q <= '0;
        end else if (SNAP) begin
            snap_q <= TIMEELAPSED;
        end
    end

endmodule

// File: tb/tb_elapsed_timer_bank.sv
// tb/tb_elapsed_timer_bank.sv - scoreboard bench for elapsed_timer_bank
module tb_elapsed_timer_bank;

    localparam int CH = 2;
    localparam int CW = 4;
    localparam int TD = 4;
    localparam int PW = 3;

    logic               MCLK;
    logic               nRESET;
    logic [CH-1:0]      nSTART;
    logic [CH-1:0]      nCLR;
    logic [CH-1:0]      PAUSE;
    logic               SNAP;
    logic [CH*CW-1:0]   TIMEELAPSED;
    logic [CH*CW-1:0]   SNAPSHOT;
    logic [CH-1:0]      RUNNING;
    logic [CH-1:0]      OVFL;

    elapsed_timer_bank #(
        .CHANNELS (CH),
        .COUNT_W  (CW),
        .TICK_DIV (TD),
        .PRESC_W  (PW)
    ) dut (
        .MCLK        (MCLK),
        .nRESET      (nRESET),
        .nSTART      (nSTART),
        .nCLR        (nCLR),
        .PAUSE       (PAUSE),
        .SNAP        (SNAP),
        .TIMEELAPSED (TIMEELAPSED),
        .SNAPSHOT    (SNAPSHOT),
        .RUNNING     (RUNNING),
        .OVFL        (OVFL)
    );

    typedef enum int {F_TIME, F_SNAP, F_RUN, F_OVFL} fld_t;

    typedef struct {
        int    due;
        fld_t  f;
        int    ch;
        int    val;
        string name;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    always @(posedge MCLK) cyc = cyc + 1;

    function automatic int get_act(input fld_t f, input int ch);
        case (f)
            F_TIME:  return 32'(TIMEELAPSED[ch*CW +: CW]);
            F_SNAP:  return 32'(SNAPSHOT[ch*CW +: CW]);
            F_RUN:   return 32'(RUNNING[ch]);
            default: return 32'(OVFL[ch]);
        endcase
    endfunction

    task automatic push_exp(input int off, input fld_t f, input int ch, input int val, input string name);
        exp_t e;
        e.due  = cyc + off;
        e.f    = f;
        e.ch   = ch;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge MCLK);
        #1;
    endtask

    // monitor: compare every expectation that falls due on this cycle
    always @(negedge MCLK) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                int act;
                act = get_act(sb[i].f, sb[i].ch);
                n_tests = n_tests + 1;
                if (act != sb[i].val) begin
                    n_fail = n_fail + 1;
                    $display("FAIL %s ch%0d cyc%0d: got %0d expected %0d",
                             sb[i].name, sb[i].ch, cyc, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        nRESET = 1'b0;
        nSTART = '1;
        nCLR   = '1;
        PAUSE  = '0;
        SNAP   = 1'b0;
        step(2);
        push_exp(0, F_TIME, 0, 0, "rst_time");
        push_exp(0, F_TIME, 1, 0, "rst_time");
        push_exp(0, F_SNAP, 0, 0, "rst_snap");
        push_exp(0, F_RUN,  0, 0, "rst_run");
        push_exp(0, F_OVFL, 1, 0, "rst_ovfl");
        nRESET = 1'b1;
        step(1);

        // 1: single start pulse, first tick after TD cycles
        nSTART[0] = 1'b0;
        push_exp(1,  F_RUN,  0, 1, "t1_run");
        push_exp(4,  F_TIME, 0, 0, "t1_pre_tick");
        push_exp(5,  F_TIME, 0, 1, "t1_tick1");
        push_exp(13, F_TIME, 0, 3, "t1_tick3");
        push_exp(13, F_TIME, 1, 0, "t1_ch1_idle");
        push_exp(13, F_RUN,  1, 0, "t1_ch1_run");
        step(1);
        nSTART[0] = 1'b1;
        step(12);

        // 2: pause with partial tick preserved (count 3, prescaler 2)
        step(2);
        PAUSE[0] = 1'b1;
        push_exp(1,  F_RUN,  0, 0, "t2_hold_run");
        push_exp(10, F_RUN,  0, 0, "t2_hold_run_end");
        push_exp(10, F_TIME, 0, 3, "t2_hold_frozen");
        step(10);
        PAUSE[0] = 1'b0;
        push_exp(1, F_RUN,  0, 1, "t2_resume_run");
        push_exp(2, F_TIME, 0, 3, "t2_resume_pre");
        push_exp(3, F_TIME, 0, 4, "t2_resume_tick");
        step(3);

        // 3: overflow after 16 ticks
        nCLR[0] = 1'b0;
        push_exp(1, F_TIME, 0, 0, "t3_clr_time");
        push_exp(1, F_RUN,  0, 0, "t3_clr_run");
        step(1);
        nCLR[0] = 1'b1;
        nSTART[0] = 1'b0;
        push_exp(61, F_TIME, 0, 15, "t3_count15");
        push_exp(61, F_OVFL, 0, 0,  "t3_no_ovfl");
        push_exp(65, F_OVFL, 0, 1,  "t3_ovfl");
`ifdef TIMECNT_WRAP_EN
        push_exp(65, F_TIME, 0, 0,  "t3_wrap0");
        push_exp(69, F_TIME, 0, 1,  "t3_wrap1");
        push_exp(69, F_OVFL, 0, 1,  "t3_ovfl_sticky");
`else
        push_exp(65, F_TIME, 0, 15, "t3_sat");
        push_exp(69, F_TIME, 0, 15, "t3_sat_hold");
        push_exp(69, F_RUN,  0, 1,  "t3_sat_run");
`endif
        step(1);
        nSTART[0] = 1'b1;
        step(69);

        // reset clears a flagged, running channel
        nRESET = 1'b0;
        push_exp(1, F_OVFL, 0, 0, "rstA_ovfl");
        push_exp(1, F_TIME, 0, 0, "rstA_time");
        push_exp(1, F_RUN,  0, 0, "rstA_run");
        step(1);
        nRESET = 1'b1;
        step(1);

        // 4: coherent snapshot with ch0=5, ch1=2, then clear ch1 only
        nSTART[0] = 1'b0;
        step(1);
        nSTART = '1;
        step(11);
        nSTART[1] = 1'b0;
        step(1);
        nSTART = '1;
        step(8);
        push_exp(0, F_TIME, 0, 5, "t4_live0");
        push_exp(0, F_TIME, 1, 2, "t4_live1");
        SNAP = 1'b1;
        push_exp(1, F_SNAP, 0, 5, "t4_snap0");
        push_exp(1, F_SNAP, 1, 2, "t4_snap1");
        step(1);
        SNAP = 1'b0;
        push_exp(3, F_SNAP, 0, 5, "t4_snap_hold");
        push_exp(3, F_TIME, 0, 6, "t4_live0_next");
        push_exp(3, F_TIME, 1, 3, "t4_live1_next");
        step(3);
        nCLR[1] = 1'b0;
        push_exp(1, F_TIME, 1, 0, "t4_clr1_time");
        push_exp(1, F_RUN,  1, 0, "t4_clr1_run");
        push_exp(1, F_TIME, 0, 6, "t4_ch0_kept");
        push_exp(1, F_RUN,  0, 1, "t4_ch0_run");
        step(1);
        nCLR = '1;
        push_exp(3, F_TIME, 0, 7, "t4_ch0_7");
        push_exp(3, F_TIME, 1, 0, "t4_ch1_idle");
        step(3);

        // 5: reset mid-run with start held low and SNAP high
        nRESET = 1'b0;
        nSTART = '0;
        SNAP   = 1'b1;
        push_exp(1, F_TIME, 0, 0, "t5_time");
        push_exp(1, F_SNAP, 0, 0, "t5_snap0");
        push_exp(1, F_SNAP, 1, 0, "t5_snap1");
        push_exp(1, F_RUN,  0, 0, "t5_run");
        step(2);
        push_exp(0, F_RUN,  0, 0, "t5_run_in_rst");
        push_exp(0, F_SNAP, 0, 0, "t5_snap_ignored");
        nRESET = 1'b1;
        SNAP   = 1'b0;
        push_exp(1, F_RUN,  0, 1, "t5_restart0");
        push_exp(1, F_RUN,  1, 1, "t5_restart1");
        push_exp(1, F_TIME, 0, 0, "t5_restart_time");
        step(1);
        nSTART = '1;
        step(1);

        // 6: clear and start together in IDLE keeps the channel idle
        nCLR = '0;
        push_exp(1, F_RUN, 0, 0, "t6_clr0");
        push_exp(1, F_RUN, 1, 0, "t6_clr1");
        step(1);
        nCLR = '1;
        nCLR[0] = 1'b0;
        nSTART  = '0;
        push_exp(1, F_RUN,  0, 0, "t6_stay_idle");
        push_exp(1, F_RUN,  1, 1, "t6_ch1_start");
        push_exp(3, F_RUN,  0, 0, "t6_still_idle");
        push_exp(5, F_TIME, 0, 0, "t6_time0");
        push_exp(5, F_TIME, 1, 1, "t6_ch1_tick");
        step(1);
        nCLR   = '1;
        nSTART = '1;
        step(6);

        if (sb.size() != 0) begin
            n_tests = n_tests + 1;
            n_fail  = n_fail + 1;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
